xif_offload_issuer: RTL and testbench

// Core-side initiator for the eXtension interface (issue/commit/result channels).
// - Takes one offload request at a time from a simple valid/ready upstream port.
// - Drives the request to an external coprocessor (e.g. the CNTB unit): issue, then commit, then collect the result.
// - Returns a single response with a status code.
// - Used as a standalone X-IF driver for coprocessor bring-up and as the offload path of lightweight masters.

---
 rtl/xif_offload_issuer.sv | 197 +++++++++++++++++++
 tb/tb_xif_offload_issuer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/xif_offload_issuer.sv
// rtl/xif_offload_issuer.sv - eXtension-interface initiator: issue, commit, collect result, respond.
// Optional performance counters are built when XIF_ISSUER_PERF_EN is defined.
module xif_offload_issuer #(
  parameter int X_ID_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_instr_i,
  input  logic [31:0]           req_rs0_i,
  input  logic [31:0]           req_rs1_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_status_o,
  output logic [31:0]           rsp_data_o,
  output logic [4:0]            rsp_rd_o,
  output logic                  rsp_we_o,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [31:0]           issue_instr_o,
  output logic [X_ID_WIDTH-1:0] issue_id_o,
  output logic [31:0]           issue_rs0_o,
  output logic [31:0]           issue_rs1_o,
  output logic [1:0]            issue_rs_valid_o,
  input  logic                  issue_accept_i,
  input  logic                  issue_writeback_i,
  output logic                  commit_valid_o,
  output logic [X_ID_WIDTH-1:0] commit_id_o,
  output logic                  commit_kill_o,
  input  logic                  kill_i,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  input  logic [X_ID_WIDTH-1:0] result_id_i,
  input  logic [31:0]           result_data_i,
  input  logic [4:0]            result_rd_i,
  input  logic                  result_we_i,
  output logic                  err_o,
  output logic [31:0]           perf_issued_o,
  output logic [31:0]           perf_rejected_o,
  output logic [31:0]           perf_timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_REJECT  = 2'b01;
  localparam logic [1:0] ST_KILLED  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, COMMIT, WAIT_RESULT, RESPOND} state_t;
  state_t state, state_nxt;

  logic [31:0]           instr_q, rs0_q, rs1_q;
  logic [X_ID_WIDTH-1:0] cur_id, next_id;
  logic                  wb_q;
  logic [CW-1:0]         wait_cnt;

  logic req_hs, issue_hs, res_hit, res_miss, expired, rsp_hs;

  assign req_hs   = (state == IDLE) && req_valid_i;
  assign issue_hs = (state == ISSUE) && issue_ready_i;
  assign res_hit  = (state == WAIT_RESULT) && result_valid_i && (result_id_i == cur_id);
  assign res_miss = (state == WAIT_RESULT) && result_valid_i && (result_id_i != cur_id);
  assign expired  = (state == WAIT_RESULT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_hs   = (state == RESPOND) && rsp_ready_i;

  assign issue_instr_o    = instr_q;
  assign issue_rs0_o      = rs0_q;
  assign issue_rs1_o      = rs1_q;
  assign issue_id_o       = cur_id;
  assign issue_rs_valid_o = {2{issue_valid_o}};
  assign commit_id_o      = cur_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready_o    = 1'b0;
    issue_valid_o  = 1'b0;
    commit_valid_o = 1'b0;
    commit_kill_o  = 1'b0;
    result_ready_o = 1'b0;
    rsp_valid_o    = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue_valid_o = 1'b1;
        if (issue_ready_i) state_nxt = issue_accept_i ? COMMIT : RESPOND;
      end
      COMMIT: begin
        commit_valid_o = 1'b1;
        commit_kill_o  = kill_i;
        state_nxt      = (!kill_i && wb_q) ? WAIT_RESULT : RESPOND;
      end
      WAIT_RESULT: begin
        result_ready_o = 1'b1;
        if (res_hit || expired) state_nxt = RESPOND;
      end
      RESPOND: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q      <= '0;
      rs0_q        <= '0;
      rs1_q        <= '0;
      cur_id       <= '0;
      next_id      <= '0;
      wb_q         <= 1'b0;
      wait_cnt     <= '0;
      rsp_status_o <= ST_OK;
      rsp_data_o   <= '0;
      rsp_rd_o     <= '0;
      rsp_we_o     <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if (req_hs) begin
        instr_q <= req_instr_i;
        rs0_q   <= req_rs0_i;
        rs1_q   <= req_rs1_i;
        cur_id  <= next_id;
      end
      if (issue_hs) begin
        wb_q <= issue_writeback_i;
        if (!issue_accept_i) begin
          rsp_status_o <= ST_REJECT;
          rsp_rd_o     <= instr_q[11:7];
          rsp_we_o     <= 1'b0;
          rsp_data_o   <= '0;
        end
      end
      // Preload the no-result response here; WAIT_RESULT overwrites it on a hit.
      if (state == COMMIT) begin
        rsp_status_o <= kill_i ? ST_KILLED : ST_OK;
        rsp_rd_o     <= instr_q[11:7];
        rsp_we_o     <= 1'b0;
        rsp_data_o   <= '0;
        wait_cnt     <= '0;
      end
      if (state == WAIT_RESULT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (res_hit) begin
          rsp_status_o <= ST_OK;
          rsp_data_o   <= result_we_i ? result_data_i : 32'd0;
          rsp_rd_o     <= result_rd_i;
          rsp_we_o     <= result_we_i;
        end else if (expired) begin
          rsp_status_o <= ST_TIMEOUT;
          rsp_data_o   <= '0;
          rsp_we_o     <= 1'b0;
        end
      end
      if (res_miss) err_o <= 1'b1;
      if (rsp_hs) next_id <= next_id + 1'b1;
    end
  end

`ifdef XIF_ISSUER_PERF_EN
  logic [31:0] cnt_issued, cnt_rejected, cnt_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_issued   <= '0;
      cnt_rejected <= '0;
      cnt_timeout  <= '0;
    end else begin
      if (issue_hs && issue_accept_i && cnt_issued != 32'hFFFF_FFFF)
        cnt_issued <= cnt_issued + 1'b1;
      if (issue_hs && !issue_accept_i && cnt_rejected != 32'hFFFF_FFFF)
        cnt_rejected <= cnt_rejected + 1'b1;
      if (expired && !res_hit && cnt_timeout != 32'hFFFF_FFFF)
        cnt_timeout <= cnt_timeout + 1'b1;
    end
  end

  assign perf_issued_o   = cnt_issued;
  assign perf_rejected_o = cnt_rejected;
  assign perf_timeout_o  = cnt_timeout;
`else
  assign perf_issued_o   = '0;
  assign perf_rejected_o = '0;
  assign perf_timeout_o  = '0;
`endif

endmodule

// File: tb/tb_xif_offload_issuer.sv
// tb/tb_xif_offload_issuer.sv - directed plus randomized checks of xif_offload_issuer.
// Perf expectations follow XIF_ISSUER_PERF_EN.
module tb_xif_offload_issuer;
  localparam int IDW = 4;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid_i = 0, req_ready_o;
  logic [31:0] req_instr_i = 0, req_rs0_i = 0, req_rs1_i = 0;
  logic rsp_valid_o, rsp_ready_i = 0;
  logic [1:0] rsp_status_o;
  logic [31:0] rsp_data_o;
  logic [4:0] rsp_rd_o;
  logic rsp_we_o;
  logic issue_valid_o, issue_ready_i = 0;
  logic [31:0] issue_instr_o, issue_rs0_o, issue_rs1_o;
  logic [IDW-1:0] issue_id_o, commit_id_o;
  logic [1:0] issue_rs_valid_o;
  logic issue_accept_i = 0, issue_writeback_i = 0;
  logic commit_valid_o, commit_kill_o, kill_i = 0;
  logic result_valid_i = 0, result_ready_o;
  logic [IDW-1:0] result_id_i = 0;
  logic [31:0] result_data_i = 0;
  logic [4:0] result_rd_i = 0;
  logic result_we_i = 0;
  logic err_o;
  logic [31:0] perf_issued_o, perf_rejected_o, perf_timeout_o;

  xif_offload_issuer #(.X_ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
    .req_rs0_i(req_rs0_i), .req_rs1_i(req_rs1_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_status_o(rsp_status_o),
    .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o), .rsp_we_o(rsp_we_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_instr_o(issue_instr_o),
    .issue_id_o(issue_id_o), .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o),
    .issue_rs_valid_o(issue_rs_valid_o), .issue_accept_i(issue_accept_i),
    .issue_writeback_i(issue_writeback_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
    .kill_i(kill_i),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o), .result_id_i(result_id_i),
    .result_data_i(result_data_i), .result_rd_i(result_rd_i), .result_we_i(result_we_i),
    .err_o(err_o), .perf_issued_o(perf_issued_o), .perf_rejected_o(perf_rejected_o),
    .perf_timeout_o(perf_timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_id = 0;
  bit exp_err = 0;
  int n_iss = 0, n_rej = 0, n_to = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_perf();
`ifdef XIF_ISSUER_PERF_EN
    check("perf_issued", perf_issued_o, 32'(n_iss));
    check("perf_rejected", perf_rejected_o, 32'(n_rej));
    check("perf_timeout", perf_timeout_o, 32'(n_to));
`else
    check("perf_issued", perf_issued_o, 32'd0);
    check("perf_rejected", perf_rejected_o, 32'd0);
    check("perf_timeout", perf_timeout_o, 32'd0);
`endif
  endtask

  // Async pulse placed between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    req_valid_i = 0; issue_ready_i = 0; kill_i = 0; result_valid_i = 0; rsp_ready_i = 0;
    rst = 1;
    #1;
    check("rst_issue_valid", 32'(issue_valid_o), 32'd0);
    check("rst_commit_valid", 32'(commit_valid_o), 32'd0);
    check("rst_result_ready", 32'(result_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_issue_id", 32'(issue_id_o), 32'd0);
    check("rst_rsp_status", 32'(rsp_status_o), 32'd0);
    check("rst_perf", perf_issued_o | perf_rejected_o | perf_timeout_o, 32'd0);
    #1;
    rst = 0;
    exp_id = 0; exp_err = 0; n_iss = 0; n_rej = 0; n_to = 0;
  endtask

  // mode: 0 matching result at rdly, 1 foreign id first then match at rdly, 2 no result.
  // abort: 0 none, 1 reset in WAIT_RESULT, 2 reset in RESPOND.
  task automatic run_txn(input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1,
                         input int iwait, input bit acc, input bit wb, input bit kill,
                         input int mode, input int rdly, input logic [31:0] rdata,
                         input logic [4:0] rrd, input bit rwe, input int rwait, input int abort);
    logic [IDW-1:0] id;
    logic [1:0] est;
    logic [31:0] edata;
    logic [4:0] erd;
    bit ewe, chk_rd;
    id = exp_id[IDW-1:0];
    est = 2'd0; edata = 0; erd = 0; ewe = 0; chk_rd = 0;
    req_valid_i = 1; req_instr_i = instr; req_rs0_i = rs0; req_rs1_i = rs1;
    @(negedge clk);
    check("req_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 0; req_instr_i = $urandom; req_rs0_i = $urandom; req_rs1_i = $urandom;
    result_valid_i = 1; result_id_i = id; result_data_i = $urandom;
    for (int i = 0; i <= iwait; i++) begin
      issue_ready_i = (i == iwait); issue_accept_i = acc; issue_writeback_i = wb;
      @(negedge clk);
      check("issue_valid", 32'(issue_valid_o), 32'd1);
      check("issue_id", 32'(issue_id_o), 32'(id));
      check("issue_instr", issue_instr_o, instr);
      check("issue_rs0", issue_rs0_o, rs0);
      check("issue_rs1", issue_rs1_o, rs1);
      check("issue_rs_valid", 32'(issue_rs_valid_o), 32'd3);
      check("result_ready_issue", 32'(result_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    issue_ready_i = 0; result_valid_i = 0;
    if (!acc) begin
      est = 2'd1; erd = instr[11:7]; chk_rd = 1; n_rej++;
    end else begin
      n_iss++;
      kill_i = kill;
      @(negedge clk);
      check("commit_valid", 32'(commit_valid_o), 32'd1);
      check("commit_id", 32'(commit_id_o), 32'(id));
      check("commit_kill", 32'(commit_kill_o), 32'(kill));
      check("result_ready_commit", 32'(result_ready_o), 32'd0);
      @(posedge clk); #1;
      kill_i = 0;
      if (kill) est = 2'd2;
      else if (wb) begin
        est = 2'd3;
        for (int w = 0; w < TO; w++) begin
          if (abort == 1 && w == 2) begin
            do_reset();
            return;
          end
          result_valid_i = 0;
          if (mode != 2 && w == rdly) begin
            result_valid_i = 1; result_id_i = id; result_data_i = rdata;
            result_rd_i = rrd; result_we_i = rwe;
          end else if (mode == 1 && w == 0) begin
            result_valid_i = 1; result_id_i = id ^ 4'd3; result_data_i = $urandom;
            result_rd_i = 5'($urandom); result_we_i = 1;
          end
          @(negedge clk);
          check("result_ready_wait", 32'(result_ready_o), 32'd1);
          check("rsp_valid_wait", 32'(rsp_valid_o), 32'd0);
          check("commit_valid_wait", 32'(commit_valid_o), 32'd0);
          @(posedge clk); #1;
          if (mode == 1 && w == 0) exp_err = 1;
          if (mode != 2 && w == rdly) begin
            est = 2'd0; edata = rwe ? rdata : 32'd0; erd = rrd; ewe = rwe; chk_rd = 1;
            break;
          end
        end
        result_valid_i = 0;
        if (est == 2'd3) n_to++;
      end
    end
    if (abort == 2) begin
      @(negedge clk);
      check("rsp_valid_abort", 32'(rsp_valid_o), 32'd1);
      @(posedge clk); #1;
      do_reset();
      return;
    end
    for (int i = 0; i <= rwait; i++) begin
      rsp_ready_i = (i == rwait);
      result_valid_i = 1; result_id_i = id; result_data_i = $urandom;
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("rsp_status", 32'(rsp_status_o), 32'(est));
      check("rsp_data", rsp_data_o, edata);
      check("rsp_we", 32'(rsp_we_o), 32'(ewe));
      if (chk_rd) check("rsp_rd", 32'(rsp_rd_o), 32'(erd));
      check("err", 32'(err_o), 32'(exp_err));
      check("no_commit_rsp", 32'(commit_valid_o), 32'd0);
      check("result_ready_rsp", 32'(result_ready_o), 32'd0);
      check("req_ready_rsp", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready_i = 0; result_valid_i = 0;
    exp_id++;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready_o), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_perf();
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    do_reset();
    @(posedge clk); #1;
    // Directed scenarios: OK with writeback, reject, kill.
    run_txn(32'h0000_016b, 32'hF0, 32'd4, 0, 1, 1, 0, 0, 0, 32'd4, 5'd2, 1, 0, 0);
    run_txn(32'h0000_0F8b, 32'h1, 32'h2, 1, 0, 1, 0, 0, 0, 32'd0, 5'd0, 0, 1, 0);
    run_txn(32'h0000_030b, 32'h3, 32'h4, 0, 1, 1, 1, 0, 0, 32'd0, 5'd0, 0, 0, 0);
    do_reset();
    @(posedge clk); #1;
    // Foreign id 3 then matching id 0; then a timeout.
    run_txn(32'h0000_048b, 32'h5, 32'h6, 0, 1, 1, 0, 1, 1, 32'h55, 5'd9, 1, 0, 0);
    run_txn(32'h0000_050b, 32'h7, 32'h8, 0, 1, 1, 0, 2, 0, 32'd0, 5'd0, 0, 0, 0);
    // Matching result on the expiry cycle.
    run_txn(32'h0000_058b, 32'h9, 32'hA, 0, 1, 1, 0, 0, TO - 1, 32'hBEEF, 5'd11, 1, 0, 0);
    for (int k = 0; k < 17; k++)
      run_txn($urandom, $urandom, $urandom, 0, 1, 0, 0, 0, 0, 32'd0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      int mode, rdly;
      mode = $urandom_range(0, 3);
      if (mode == 3) mode = 0;
      rdly = (mode == 1) ? $urandom_range(1, TO - 1) : $urandom_range(0, TO - 1);
      run_txn($urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 9) != 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, mode, rdly, $urandom,
              5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
    end
    // Reset mid-WAIT_RESULT and mid-RESPOND; following issue must use id 0.
    run_txn(32'h0000_060b, 32'h1, 32'h1, 0, 1, 1, 0, 2, 0, 32'd0, 5'd0, 0, 0, 1);
    @(posedge clk); #1;
    run_txn(32'h0000_068b, 32'h2, 32'h2, 0, 1, 0, 0, 0, 0, 32'd0, 5'd0, 0, 0, 0);
    run_txn(32'h0000_070b, 32'h3, 32'h3, 0, 1, 0, 0, 0, 0, 32'd0, 5'd0, 0, 0, 2);
    @(posedge clk); #1;
    run_txn(32'h0000_078b, 32'h4, 32'h4, 0, 1, 1, 0, 0, 2, 32'h1234, 5'd15, 1, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
